// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Forwarding and load-use hazard controller for a 5-stage
//               pipeline. Shadows EX/MEM/WB destination metadata, drives the
//               ALU operand mux selects, stalls PC and IF/ID on load-use
//               hazards and keeps a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Operand mux select encoding
  localparam logic [1:0] c_SEL_REG = 2'd0;  // ID/EX register value
  localparam logic [1:0] c_SEL_WB  = 2'd1;  // WB result
  localparam logic [1:0] c_SEL_MEM = 2'd2;  // EX/MEM ALU result

  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

  // EX shadow stage
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_use_rs;
  logic              r_ex_use_rt;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  // MEM shadow stage
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;
  // WB shadow stage
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_stall;
  logic              w_ex_bubble;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // Load-use detection: the load in EX produces its data too late for the
  // dependent instruction in ID. A flushed ID instruction never stalls.
  always_comb begin
    w_stall = 1'b0;
    if (r_ex_memread && (r_ex_rd != c_REG_ZERO) && !flush_i) begin
      w_stall = (id_use_rs_i && (r_ex_rd == id_rs_i)) ||
                (id_use_rt_i && (r_ex_rd == id_rt_i));
    end
  end

  assign w_ex_bubble = w_stall || flush_i;

  // Forwarding selects: EX/MEM result wins over WB result; $zero never forwards
  always_comb begin
    w_fwd_a = c_SEL_REG;
    w_fwd_b = c_SEL_REG;
    if (r_ex_use_rs && (r_ex_rs != c_REG_ZERO)) begin
      if (r_mem_regwrite && (r_mem_rd == r_ex_rs)) begin
        w_fwd_a = c_SEL_MEM;
      end else if (r_wb_regwrite && (r_wb_rd == r_ex_rs)) begin
        w_fwd_a = c_SEL_WB;
      end
    end
    if (r_ex_use_rt && (r_ex_rt != c_REG_ZERO)) begin
      if (r_mem_regwrite && (r_mem_rd == r_ex_rt)) begin
        w_fwd_b = c_SEL_MEM;
      end else if (r_wb_regwrite && (r_wb_rd == r_ex_rt)) begin
        w_fwd_b = c_SEL_WB;
      end
    end
  end

  // Shadow pipeline advance; EX takes a bubble on stall or flush
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_use_rs    <= 1'b0;
      r_ex_use_rt    <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      if (w_ex_bubble) begin
        r_ex_rs       <= '0;
        r_ex_rt       <= '0;
        r_ex_use_rs   <= 1'b0;
        r_ex_use_rt   <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_rs       <= id_rs_i;
        r_ex_rt       <= id_rt_i;
        r_ex_use_rs   <= id_use_rs_i;
        r_ex_use_rt   <= id_use_rt_i;
        r_ex_rd       <= id_rd_i;
        r_ex_regwrite <= id_regwrite_i;
        r_ex_memread  <= id_memread_i;
      end
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
    end
  end

  // Saturating stall-cycle counter for performance monitoring
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign fwd_a_sel_o  = w_fwd_a;
  assign fwd_b_sel_o  = w_fwd_b;
  assign stall_o      = w_stall;
  assign pc_write_o   = ~w_stall;
  assign ifid_write_o = ~w_stall;
  assign stall_cnt_o  = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipelined CPU.
- Tracks destination and write-enable metadata of in-flight instructions in its own EX, MEM and WB shadow stages.
- Drives the 2-bit selects of the two 3-to-1 ALU operand multiplexers.
- Stalls PC and IF/ID on load-use hazards and counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk_i  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- id_rs_i  input  REG_AW  rs of instruction in ID
- id_rt_i  input  REG_AW  rt of instruction in ID
- id_use_rs_i  input  1  ID instruction reads rs
- id_use_rt_i  input  1  ID instruction reads rt
- id_rd_i  input  REG_AW  destination of ID instruction, already resolved rt/rd
- id_regwrite_i  input  1  ID instruction writes register file
- id_memread_i  input  1  ID instruction is a load
- flush_i  input  1  branch taken; discard ID instruction
- fwd_a_sel_o  output  2  operand-A mux select: 0 = ID/EX register value, 1 = WB result, 2 = EX/MEM ALU result
- fwd_b_sel_o  output  2  operand-B mux select, same encoding
- stall_o  output  1  load-use stall this cycle
- pc_write_o  output  1  PC update enable, equal to ~stall_o
- ifid_write_o  output  1  IF/ID update enable, equal to ~stall_o
- stall_cnt_o  output  CNT_W  saturating count of stall cycles

Behaviour:
- Internal stages:
  - EX holds rs, rt, use_rs, use_rt, rd, regwrite and memread.
  - MEM holds rd and regwrite.
  - WB holds rd and regwrite.
  - All stages advance every clock; the pipeline never freezes past ID.
- EX capture each clock:
  - If stall_o or flush_i, EX loads a bubble: all fields 0, so regwrite = 0 and memread = 0.
  - Otherwise EX loads the id_* inputs.
- MEM and WB capture rd and regwrite from the previous stage each clock.
- Reset (rst_n low, asynchronous):
  - All stage registers clear to bubble.
  - stall_cnt_o = 0.
  - Therefore fwd_*_sel_o = 0, stall_o = 0, pc_write_o = 1, ifid_write_o = 1.
  - Reset deassertion is synchronised externally. Reset mid-stream discards all tracked instructions.
- Forwarding (combinational from stage registers):
  - Operand A: sel = 2 if MEM.regwrite && MEM.rd != 0 && MEM.rd == EX.rs && EX.use_rs.
  - Else sel = 1 if WB.regwrite && WB.rd != 0 && WB.rd == EX.rs && EX.use_rs.
  - Else sel = 0.
  - Operand B uses the same rules with rt/use_rt.
  - EX/MEM has priority over WB when both match.
  - Register 0 is never forwarded.
  - Select value 3 is never driven.
- Load-use stall (combinational):
  - stall_o = EX.memread && EX.rd != 0 && ((id_use_rs_i && EX.rd == id_rs_i) || (id_use_rt_i && EX.rd == id_rt_i)) && !flush_i.
  - flush_i has priority: a flushed instruction never stalls.
  - One stall cycle per hazard. On the next cycle the load is in MEM with a bubble in EX, so no re-stall. The consumer later forwards from WB (sel = 1).
- Register file is write-before-read in the same cycle, so no ID-stage forward path is required.
- Stall counter:
  - Increments by 1 on each clock with stall_o = 1.
  - Saturates at 2^CNT_W-1 with no wrap.
- Latency:
  - Selects and stall are valid in the same cycle as the inputs and stage state.
  - Stage state updates 1 cycle after capture.

Test Plan:
- Reset: hold rst_n low 3 cycles with random inputs -> sel A/B = 0, stall_o = 0, pc_write_o = 1, stall_cnt_o = 0. Assert rst_n mid-stream -> outputs clear immediately, asynchronously.
- EX hazard: add $3 (rd=3, regwrite) then sub using rs=3, rt=4 -> next cycle fwd_a_sel_o = 2, fwd_b_sel_o = 0. Add a third instruction using rt=3 -> fwd_b_sel_o = 1.
- Double hazard: add $5, add $5, then use rs=5 -> fwd_a_sel_o = 2, proving MEM priority over WB.
- Load-use: lw rd=8 then add using rs=8 -> stall_o = 1 for exactly 1 cycle with pc_write_o = 0. EX gets a bubble. Two cycles later fwd_a_sel_o = 1. stall_cnt_o = 1.
- $zero and flush: writes to rd=0 never forward (sel = 0). lw rd=8 followed by a dependent instruction with flush_i = 1 -> stall_o = 0 and the EX bubble leaves no forwarding.
- Counter saturation: CNT_W = 4, force 20 consecutive load-use pairs -> stall_cnt_o stops at 15.
